// File: rtl/countdown_timer.sv
// Loadable BCD countdown timer driven by a period strobe.
// Start/pause/clear control with registered run/expire status.
module countdown_timer #(
    parameter int DIGITS         = 4,
    parameter int TICKS_PER_UNIT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  running,
    output logic                  paused,
    output logic                  expired,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_UNIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    state_t        state;
    logic [W-1:0]  count;
    logic [PW-1:0] pre;
    logic          tick_q;
    logic          done_pend;

    logic          acc;
    logic          cnt_zero;
    logic          cnt_one;
    logic          borrow;
    logic [W-1:0]  dec_val;
    logic [W-1:0]  load_val;

    assign acc       = tick & ~tick_q;
    assign cnt_zero  = (count == '0);
    assign cnt_one   = (count == W'(1));
    assign count_bcd = count;

    // Ripple-borrow BCD decrement of the current count
    always_comb begin
        dec_val = count;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Clamp each preset digit to 9
    always_comb begin
        load_val = load_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_bcd[4*i +: 4] > 4'd9) begin
                load_val[4*i +: 4] = 4'd9;
            end
        end
    end

    // Control FSM, prescaler, count and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            pre       <= '0;
            tick_q    <= 1'b0;
            done_pend <= 1'b0;
            running   <= 1'b0;
            paused    <= 1'b0;
            expired   <= 1'b0;
            done      <= 1'b0;
        end else begin
            tick_q    <= tick;
            running   <= (state == RUN);
            paused    <= (state == PAUSE);
            expired   <= (state == EXPIRED);
            done      <= done_pend;
            done_pend <= 1'b0;
            if (clear) begin
                state <= IDLE;
                count <= '0;
                pre   <= '0;
            end else if (load) begin
                state <= IDLE;
                count <= load_val;
                pre   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !cnt_zero) begin
                            state <= RUN;
                            pre   <= '0;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (acc) begin
                            if (pre == PRE_MAX) begin
                                pre <= '0;
                                if (!cnt_zero) begin
                                    count <= dec_val;
                                end
                                if (cnt_one) begin
                                    state     <= EXPIRED;
                                    done_pend <= 1'b1;
                                end
                            end else begin
                                pre <= pre + PW'(1);
                            end
                        end
                    end
                    PAUSE: begin
                        if (start && !pause) begin
                            state <= RUN;
                        end
                    end
                    EXPIRED: begin
                        state <= EXPIRED;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios
// plus randomized control traffic against a behavioural model.
module tb_countdown_timer;

    localparam int DIGITS = 4;
    localparam int TPU    = 10;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        load;
    logic [15:0] load_bcd;
    logic        start;
    logic        pause;
    logic        clear;
    logic [15:0] count_bcd;
    logic        running;
    logic        paused;
    logic        expired;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    countdown_timer #(
        .DIGITS(DIGITS),
        .TICKS_PER_UNIT(TPU)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .load(load),
        .load_bcd(load_bcd),
        .start(start),
        .pause(pause),
        .clear(clear),
        .count_bcd(count_bcd),
        .running(running),
        .paused(paused),
        .expired(expired),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt++;
    end

    // Behavioural reference: count held as a plain integer
    int m_cnt;
    int m_pre;
    int m_mode;
    bit m_tq;
    bit m_run, m_pau, m_exp, m_done, m_dpend;

    function automatic int clamp_val(input logic [15:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'((v >> (4 * i)) & 16'hF);
            if (d > 9) d = 9;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = '0;
        int x = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x /= 10;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_pre = 0; m_mode = 0; m_tq = 0;
            m_run = 0; m_pau = 0; m_exp = 0;
            m_done = 0; m_dpend = 0;
        end else begin
            bit acc;
            acc = tick && !m_tq;
            m_tq = tick;
            m_run = (m_mode == 1);
            m_pau = (m_mode == 2);
            m_exp = (m_mode == 3);
            m_done = m_dpend;
            m_dpend = 0;
            if (clear) begin
                m_mode = 0; m_cnt = 0; m_pre = 0;
            end else if (load) begin
                m_mode = 0; m_cnt = clamp_val(load_bcd); m_pre = 0;
            end else if (m_mode == 0) begin
                if (start && m_cnt != 0) begin
                    m_mode = 1; m_pre = 0;
                end
            end else if (m_mode == 1) begin
                if (pause) m_mode = 2;
                else if (acc) begin
                    m_pre++;
                    if (m_pre == TPU) begin
                        m_pre = 0;
                        if (m_cnt > 0) m_cnt--;
                        if (m_cnt == 0) begin
                            m_mode = 3; m_dpend = 1;
                        end
                    end
                end
            end else if (m_mode == 2) begin
                if (start && !pause) m_mode = 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_bcd = v;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick = 0; load = 0; load_bcd = '0;
        start = 0; pause = 0; clear = 0;
        cyc(2);
        checks++;
        if ({count_bcd, running, paused, expired, done} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %b%b%b%b want 0000 0000",
                     count_bcd, running, paused, expired, done);
        end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_expiry();
        int d0;
        logic [15:0] exp_c;
        do_load(16'h0003);
        do_start();
        cyc(1);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL exp_running: got %b want 1", running);
        end
        d0 = done_cnt;
        for (int k = 1; k <= 3; k++) begin
            strobe(TPU);
            exp_c = 16'(3 - k);
            checks++;
            if (count_bcd !== exp_c) begin
                errors++;
                $display("FAIL exp_count_%0d: got %h want %h", k, count_bcd, exp_c);
            end
        end
        checks++;
        if ({done, expired, running} !== 3'b110) begin
            errors++;
            $display("FAIL exp_status: got done=%b exp=%b run=%b want 1 1 0",
                     done, expired, running);
        end
        cyc(3);
        checks++;
        if (done_cnt - d0 !== 1 || expired !== 1'b1 || count_bcd !== 16'h0) begin
            errors++;
            $display("FAIL exp_once: got pulses=%0d exp=%b cnt=%h want 1 1 0000",
                     done_cnt - d0, expired, count_bcd);
        end
        do_start();
        cyc(2);
        checks++;
        if (expired !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL exp_start_ignored: got exp=%b run=%b want 1 0",
                     expired, running);
        end
    endtask

    task automatic test_borrow();
        do_load(16'h1000);
        do_start();
        strobe(TPU);
        checks++;
        if (count_bcd !== 16'h0999) begin
            errors++;
            $display("FAIL borrow_1000: got %h want 0999", count_bcd);
        end
        do_load(16'h0100);
        do_start();
        strobe(TPU);
        checks++;
        if (count_bcd !== 16'h0099) begin
            errors++;
            $display("FAIL borrow_0100: got %h want 0099", count_bcd);
        end
    endtask

    task automatic test_pause_resume();
        do_load(16'h0005);
        do_start();
        strobe(7);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        strobe(20);
        checks++;
        if (count_bcd !== 16'h0005 || paused !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold: got cnt=%h paused=%b want 0005 1",
                     count_bcd, paused);
        end
        start = 1'b1;
        pause = 1'b1;
        cyc(2);
        start = 1'b0;
        pause = 1'b0;
        checks++;
        if (paused !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_start_both: got paused=%b run=%b want 1 0",
                     paused, running);
        end
        do_start();
        strobe(2);
        checks++;
        if (count_bcd !== 16'h0005) begin
            errors++;
            $display("FAIL resume_2: got %h want 0005", count_bcd);
        end
        strobe(1);
        checks++;
        if (count_bcd !== 16'h0004) begin
            errors++;
            $display("FAIL resume_3: got %h want 0004", count_bcd);
        end
    endtask

    task automatic test_hold_and_clamp();
        do_load(16'h0002);
        do_start();
        tick = 1'b1;
        cyc(50);
        tick = 1'b0;
        cyc(1);
        strobe(8);
        checks++;
        if (count_bcd !== 16'h0002) begin
            errors++;
            $display("FAIL hold_once_a: got %h want 0002", count_bcd);
        end
        strobe(1);
        checks++;
        if (count_bcd !== 16'h0001) begin
            errors++;
            $display("FAIL hold_once_b: got %h want 0001", count_bcd);
        end
        do_load(16'h00F9);
        checks++;
        if (count_bcd !== 16'h0099) begin
            errors++;
            $display("FAIL clamp_00f9: got %h want 0099", count_bcd);
        end
        do_load(16'hFAB7);
        checks++;
        if (count_bcd !== 16'h9997) begin
            errors++;
            $display("FAIL clamp_fab7: got %h want 9997", count_bcd);
        end
        do_load(16'h0000);
        do_start();
        cyc(2);
        checks++;
        if (running !== 1'b0 || count_bcd !== 16'h0) begin
            errors++;
            $display("FAIL start_zero: got run=%b cnt=%h want 0 0000",
                     running, count_bcd);
        end
    endtask

    task automatic test_clear_and_rst();
        int d0;
        do_load(16'h0007);
        do_start();
        strobe(4);
        d0 = done_cnt;
        clear = 1'b1;
        load = 1'b1;
        load_bcd = 16'h1234;
        cyc(1);
        clear = 1'b0;
        load = 1'b0;
        cyc(2);
        checks++;
        if (count_bcd !== 16'h0 || {running, paused, expired} !== 3'b000
            || done_cnt != d0) begin
            errors++;
            $display("FAIL clear_load: got cnt=%h st=%b%b%b pulses=%0d want 0000 000 0",
                     count_bcd, running, paused, expired, done_cnt - d0);
        end
        do_load(16'h0007);
        do_start();
        strobe(13);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({count_bcd, running, paused, expired, done} !== 20'h0) begin
            errors++;
            $display("FAIL async_rst: got %h %b%b%b%b want 0000 0000",
                     count_bcd, running, paused, expired, done);
        end
        cyc(1);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_random();
        int r;
        int bad = 0;
        do_load(16'h0002);
        do_start();
        for (int n = 0; n < 3000; n++) begin
            tick = 1'($urandom_range(0, 1));
            load = 0; start = 0; pause = 0; clear = 0;
            r = $urandom_range(0, 39);
            if (!tick) begin
                if (r == 0) begin
                    load = 1;
                    load_bcd = 16'($urandom_range(0, 4));
                end else if (r == 1) begin
                    load = 1;
                    load_bcd = 16'($urandom);
                end else if (r >= 2 && r <= 5) begin
                    start = 1;
                end else if (r == 6) begin
                    pause = 1;
                end else if (r == 7) begin
                    clear = 1;
                end
            end
            cyc(1);
            checks++;
            if (count_bcd !== to_bcd(m_cnt) || running !== m_run
                || paused !== m_pau || expired !== m_exp || done !== m_done) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rand_%0d: got %h %b%b%b%b want %h %b%b%b%b",
                             n, count_bcd, running, paused, expired, done,
                             to_bcd(m_cnt), m_run, m_pau, m_exp, m_done);
            end
        end
        tick = 0; load = 0; start = 0; pause = 0; clear = 0;
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_borrow();
        test_pause_resume();
        test_hold_and_clamp();
        test_clear_and_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
